// File: rtl/bus_datapath_seq_if.sv
// Host-side bundle for bus_datapath_seq: command channel, host register
// write port, observation read port and status outputs.
interface bus_datapath_seq_if #(
  parameter int W    = 32,
  parameter int NGPR = 16
);
  localparam int AW = $clog2(NGPR);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [AW-1:0] cmd_ra;
  logic [AW-1:0] cmd_rb;
  logic [AW-1:0] cmd_rd;
  logic          cmd_imm_en;
  logic [W-1:0]  cmd_imm;
  logic          wr_en;
  logic [AW-1:0] wr_sel;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_sel;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic [W-1:0]  bus_contents;
  logic          z_flag;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
           wr_en, wr_sel, wr_data, rd_sel,
    input  cmd_ready, rd_data, hi_out, lo_out, bus_contents, z_flag, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm_en, cmd_imm,
           wr_en, wr_sel, wr_data, rd_sel,
    output cmd_ready, rd_data, hi_out, lo_out, bus_contents, z_flag, busy, done
  );
endinterface

// File: rtl/bus_datapath_seq.sv
// Single-bus register-transfer datapath with its own micro-step sequencer.
// One command walks IDLE -> TA -> TB -> WB (-> WB2 for MUL/DIV) -> IDLE,
// moving one value over the shared bus per step.
module bus_datapath_seq #(
  parameter int W    = 32,
  parameter int NGPR = 16
) (
  input logic          clk,
  input logic          clr,
  bus_datapath_seq_if.slave host
);
  localparam int AW   = $clog2(NGPR);
  localparam int SW   = $clog2(W);
  localparam int NREG = 1 << AW;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_TA, S_TB, S_WB, S_WB2} state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic          imm_en_q;
  logic [W-1:0]  imm_q;
  logic [W-1:0]  y, z_hi, z_lo, hi, lo;
  logic          z_flag_q, done_q;
  logic [W-1:0]  gpr [NREG];

  logic [W-1:0]          bus_val;
  logic [W-1:0]          alu_lo, alu_hi;
  logic [SW-1:0]         shamt;
  logic [2*W-1:0]        dbl;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   quo, rem;

  // Bus source select: exactly one register drives the bus in each step.
  always_comb begin
    bus_val = '0;
    case (state)
      S_TA:    bus_val = gpr[ra_q];
      S_TB:    bus_val = imm_en_q ? imm_q : gpr[rb_q];
      S_WB:    bus_val = z_lo;
      S_WB2:   bus_val = z_hi;
      default: bus_val = '0;
    endcase
  end

  // ALU: Y is operand A, the bus carries operand B during TB.
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    shamt  = bus_val[SW-1:0];
    dbl    = '0;
    prod   = '0;
    quo    = '0;
    rem    = '0;
    case (op_q)
      OP_ADD: alu_lo = y + bus_val;
      OP_SUB: alu_lo = y - bus_val;
      OP_AND: alu_lo = y & bus_val;
      OP_OR:  alu_lo = y | bus_val;
      OP_SHR: alu_lo = y >> shamt;
      OP_SHL: alu_lo = y << shamt;
      OP_ROR: begin
        dbl    = {y, y} >> shamt;
        alu_lo = dbl[W-1:0];
      end
      OP_ROL: begin
        dbl    = {y, y} << shamt;
        alu_lo = dbl[2*W-1:W];
      end
      OP_NEG: alu_lo = '0 - y;
      OP_NOT: alu_lo = ~y;
      OP_MUL: begin
        prod   = $signed({{W{y[W-1]}}, y}) * $signed({{W{bus_val[W-1]}}, bus_val});
        alu_lo = prod[W-1:0];
        alu_hi = prod[2*W-1:W];
      end
      OP_DIV: begin
        if (bus_val == '0) begin
          alu_lo = '1;
          alu_hi = y;
        end else begin
          quo    = $signed(y) / $signed(bus_val);
          rem    = $signed(y) % $signed(bus_val);
          alu_lo = quo;
          alu_hi = rem;
        end
      end
      default: alu_lo = '0;
    endcase
  end

  // Sequencer and every architectural register; host writes only land while idle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= S_IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      y        <= '0;
      z_hi     <= '0;
      z_lo     <= '0;
      hi       <= '0;
      lo       <= '0;
      z_flag_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host.wr_en && (int'(host.wr_sel) < NGPR)) gpr[host.wr_sel] <= host.wr_data;
          if (host.cmd_valid) begin
            op_q     <= host.cmd_op;
            ra_q     <= host.cmd_ra;
            rb_q     <= host.cmd_rb;
            rd_q     <= host.cmd_rd;
            imm_en_q <= host.cmd_imm_en;
            imm_q    <= host.cmd_imm;
            state    <= S_TA;
          end
        end
        S_TA: begin
          y     <= bus_val;
          state <= S_TB;
        end
        S_TB: begin
          z_hi  <= alu_hi;
          z_lo  <= alu_lo;
          state <= S_WB;
        end
        S_WB: begin
          if (op_q <= OP_NOT) begin
            if (int'(rd_q) < NGPR) gpr[rd_q] <= bus_val;
            z_flag_q <= (z_lo == '0);
            done_q   <= 1'b1;
            state    <= S_IDLE;
          end else if (op_q == OP_MUL || op_q == OP_DIV) begin
            lo       <= bus_val;
            z_flag_q <= (z_lo == '0);
            state    <= S_WB2;
          end else begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_WB2: begin
          hi     <= bus_val;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host.cmd_ready    = (state == S_IDLE);
  assign host.busy         = (state != S_IDLE);
  assign host.rd_data      = gpr[host.rd_sel];
  assign host.hi_out       = hi;
  assign host.lo_out       = lo;
  assign host.bus_contents = bus_val;
  assign host.z_flag       = z_flag_q;
  assign host.done         = done_q;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench: a W=32/NGPR=16 and a W=16/NGPR=8 instance run in
// lockstep from the same stimulus, each compared every cycle against a
// timeline model of the command semantics.
module tb_bus_datapath_seq;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_imm_en, wr_en;
  logic [3:0]  cmd_op, cmd_ra, cmd_rb, cmd_rd, wr_sel, rd_sel;
  logic [31:0] cmd_imm, wr_data;

  bus_datapath_seq_if #(.W(32), .NGPR(16)) big_if ();
  bus_datapath_seq_if #(.W(16), .NGPR(8))  small_if ();

  bus_datapath_seq #(.W(32), .NGPR(16)) dut_big   (.clk(clk), .clr(clr), .host(big_if));
  bus_datapath_seq #(.W(16), .NGPR(8))  dut_small (.clk(clk), .clr(clr), .host(small_if));

  // Both instances see the same stimulus, truncated to their widths.
  assign big_if.cmd_valid    = cmd_valid;
  assign big_if.cmd_op       = cmd_op;
  assign big_if.cmd_ra       = cmd_ra;
  assign big_if.cmd_rb       = cmd_rb;
  assign big_if.cmd_rd       = cmd_rd;
  assign big_if.cmd_imm_en   = cmd_imm_en;
  assign big_if.cmd_imm      = cmd_imm;
  assign big_if.wr_en        = wr_en;
  assign big_if.wr_sel       = wr_sel;
  assign big_if.wr_data      = wr_data;
  assign big_if.rd_sel       = rd_sel;
  assign small_if.cmd_valid  = cmd_valid;
  assign small_if.cmd_op     = cmd_op;
  assign small_if.cmd_ra     = cmd_ra[2:0];
  assign small_if.cmd_rb     = cmd_rb[2:0];
  assign small_if.cmd_rd     = cmd_rd[2:0];
  assign small_if.cmd_imm_en = cmd_imm_en;
  assign small_if.cmd_imm    = cmd_imm[15:0];
  assign small_if.wr_en      = wr_en;
  assign small_if.wr_sel     = wr_sel[2:0];
  assign small_if.wr_data    = wr_data[15:0];
  assign small_if.rd_sel     = rd_sel[2:0];

  logic [63:0] act_rd [2], act_hi [2], act_lo [2], act_bus [2];
  logic        act_ready [2], act_busy [2], act_done [2], act_z [2];
  assign act_rd[0]    = 64'(big_if.rd_data);
  assign act_rd[1]    = 64'(small_if.rd_data);
  assign act_hi[0]    = 64'(big_if.hi_out);
  assign act_hi[1]    = 64'(small_if.hi_out);
  assign act_lo[0]    = 64'(big_if.lo_out);
  assign act_lo[1]    = 64'(small_if.lo_out);
  assign act_bus[0]   = 64'(big_if.bus_contents);
  assign act_bus[1]   = 64'(small_if.bus_contents);
  assign act_ready[0] = big_if.cmd_ready;
  assign act_ready[1] = small_if.cmd_ready;
  assign act_busy[0]  = big_if.busy;
  assign act_busy[1]  = small_if.busy;
  assign act_done[0]  = big_if.done;
  assign act_done[1]  = small_if.done;
  assign act_z[0]     = big_if.z_flag;
  assign act_z[1]     = small_if.z_flag;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic checkOutput(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (inst %0d) at %0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_w [2] = '{32, 16};
  int          m_n [2] = '{16, 8};
  logic [63:0] m_gpr [2][16];
  logic [63:0] m_hi [2], m_lo [2], m_a [2], m_b [2];
  logic [127:0] m_res [2];
  logic        m_z [2], m_done [2];
  int          m_rd [2];
  logic [3:0]  m_op = 4'd0;
  int          m_step = 0;

  function automatic logic [63:0] mk(input int w);
    return (64'h1 << w) - 64'h1;
  endfunction

  function automatic longint sx(input logic [63:0] v, input int w);
    longint t;
    t = longint'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  // Returns {hi, lo} of the command result at width w.
  function automatic logic [127:0] alu_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] m, lo, hi;
    longint p, q, r;
    int s;
    m  = mk(w);
    s  = int'(b & 64'(w - 1));
    lo = 64'h0;
    hi = 64'h0;
    case (op)
      4'd0:  lo = (a + b) & m;
      4'd1:  lo = (a - b) & m;
      4'd2:  lo = a & b;
      4'd3:  lo = a | b;
      4'd4:  lo = a >> s;
      4'd5:  lo = (a << s) & m;
      4'd6:  lo = ((a >> s) | (a << (w - s))) & m;
      4'd7:  lo = ((a << s) | (a >> (w - s))) & m;
      4'd8:  lo = (64'h0 - a) & m;
      4'd9:  lo = ~a & m;
      4'd10: begin
        p  = sx(a, w) * sx(b, w);
        lo = 64'(p) & m;
        hi = 64'(p >>> w) & m;
      end
      4'd11: begin
        if (b == 64'h0) begin
          lo = m;
          hi = a;
        end else begin
          q  = sx(a, w) / sx(b, w);
          r  = sx(a, w) % sx(b, w);
          lo = 64'(q) & m;
          hi = 64'(r) & m;
        end
      end
      default: lo = 64'h0;
    endcase
    return {hi, lo};
  endfunction

  function automatic logic [63:0] regAfterWrite(input int k, input int idx);
    if (wr_en && (int'(wr_sel) & (m_n[k] - 1)) == idx) return 64'(wr_data) & mk(m_w[k]);
    return m_gpr[k][idx];
  endfunction

  function automatic logic [63:0] opA(input int k);
    return regAfterWrite(k, int'(cmd_ra) & (m_n[k] - 1));
  endfunction

  function automatic logic [63:0] opB(input int k);
    if (cmd_imm_en) return 64'(cmd_imm) & mk(m_w[k]);
    return regAfterWrite(k, int'(cmd_rb) & (m_n[k] - 1));
  endfunction

  // Model timeline: accept, then steps 1..3 (4 for MUL/DIV) edges later.
  always @(posedge clk) begin
    if (!clr) begin
      m_step <= 0;
      for (int k = 0; k < 2; k++) begin
        m_done[k] <= 1'b0;
        m_z[k]    <= 1'b0;
        m_hi[k]   <= 64'h0;
        m_lo[k]   <= 64'h0;
        for (int i = 0; i < 16; i++) m_gpr[k][i] <= 64'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) m_done[k] <= 1'b0;
      if (m_step == 0) begin
        for (int k = 0; k < 2; k++)
          if (wr_en) m_gpr[k][int'(wr_sel) & (m_n[k] - 1)] <= 64'(wr_data) & mk(m_w[k]);
        if (cmd_valid) begin
          m_step <= 1;
          m_op   <= cmd_op;
          for (int k = 0; k < 2; k++) begin
            m_a[k]   <= opA(k);
            m_b[k]   <= opB(k);
            m_res[k] <= alu_model(cmd_op, opA(k), opB(k), m_w[k]);
            m_rd[k]  <= int'(cmd_rd) & (m_n[k] - 1);
          end
        end
      end else if (m_step < 3) begin
        m_step <= m_step + 1;
      end else if (m_step == 3) begin
        if (m_op <= 4'd9) begin
          for (int k = 0; k < 2; k++) begin
            m_gpr[k][m_rd[k]] <= m_res[k][63:0];
            m_z[k]            <= (m_res[k][63:0] == 64'h0);
            m_done[k]         <= 1'b1;
          end
          m_step <= 0;
        end else if (m_op == 4'd10 || m_op == 4'd11) begin
          for (int k = 0; k < 2; k++) begin
            m_lo[k] <= m_res[k][63:0];
            m_z[k]  <= (m_res[k][63:0] == 64'h0);
          end
          m_step <= 4;
        end else begin
          for (int k = 0; k < 2; k++) m_done[k] <= 1'b1;
          m_step <= 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          m_hi[k]   <= m_res[k][127:64];
          m_done[k] <= 1'b1;
        end
        m_step <= 0;
      end
    end
  end

  function automatic logic [63:0] expBus(input int k);
    case (m_step)
      1:       return m_a[k];
      2:       return m_b[k];
      3:       return m_res[k][63:0];
      4:       return m_res[k][127:64];
      default: return 64'h0;
    endcase
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("cmd_ready", k, 64'(act_ready[k]), 64'(m_step == 0));
        checkOutput("busy", k, 64'(act_busy[k]), 64'(m_step != 0));
        checkOutput("done", k, 64'(act_done[k]), 64'(m_done[k]));
        checkOutput("z_flag", k, 64'(act_z[k]), 64'(m_z[k]));
        checkOutput("hi_out", k, act_hi[k], m_hi[k]);
        checkOutput("lo_out", k, act_lo[k], m_lo[k]);
        checkOutput("rd_data", k, act_rd[k], m_gpr[k][int'(rd_sel) & (m_n[k] - 1)]);
        if (!(m_step == 3 && m_op >= 4'd12))
          checkOutput("bus_contents", k, act_bus[k], expBus(k));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic applyStimulus(input bit cv, input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] rd, input bit ie, input logic [31:0] im,
                               input bit we, input logic [3:0] ws, input logic [31:0] wd);
    cmd_valid  = cv;
    cmd_op     = op;
    cmd_ra     = ra;
    cmd_rb     = rb;
    cmd_rd     = rd;
    cmd_imm_en = ie;
    cmd_imm    = im;
    wr_en      = we;
    wr_sel     = ws;
    wr_data    = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wr_en     = 1'b0;
  endtask

  task automatic hostWrite(input logic [3:0] ws, input logic [31:0] wd);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b1, ws, wd);
  endtask

  task automatic waitDone(output int lat, output int bz);
    lat = 0;
    bz  = 0;
    while (big_if.done !== 1'b1 && lat < 12) begin
      if (big_if.cmd_ready !== 1'b1) bz++;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("done_seen", 0, 64'(big_if.done), 64'd1);
  endtask

  task automatic runCmd(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd,
                        input bit ie, input logic [31:0] im, output int lat, output int bz);
    applyStimulus(1'b1, op, ra, rb, rd, ie, im, 1'b0, 4'd0, 32'h0);
    waitDone(lat, bz);
  endtask

  task automatic peekReg(input logic [3:0] idx, input logic [31:0] exp, input string name);
    @(posedge clk);
    #2;
    rd_sel = idx;
    #1;
    checkOutput(name, 0, 64'(big_if.rd_data), 64'(exp));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bz;
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_ra = 4'd0; cmd_rb = 4'd0; cmd_rd = 4'd0;
    cmd_imm_en = 1'b0; cmd_imm = 32'h0; wr_en = 1'b0; wr_sel = 4'd0; wr_data = 32'h0; rd_sel = 4'd0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_ready", 0, 64'(big_if.cmd_ready), 64'd1);
    checkOutput("rst_done", 0, 64'(big_if.done), 64'd0);
    checkOutput("rst_lo", 0, 64'(big_if.lo_out), 64'd0);
    checkOutput("rst_z", 0, 64'(big_if.z_flag), 64'd0);
    clr = 1'b1;
    peekReg(4'd1, 32'd0, "rst_r1");

    $display("[TB] ADD / SUB / SHL / ROR");
    hostWrite(4'd1, 32'd5);
    hostWrite(4'd2, 32'd7);
    runCmd(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, lat, bz);
    checkOutput("add_latency", 0, 64'(lat), 64'd3);
    checkOutput("add_busy_cycles", 0, 64'(bz), 64'd3);
    checkOutput("add_z", 0, 64'(big_if.z_flag), 64'd0);
    peekReg(4'd3, 32'd12, "add_r3");
    checkOutput("done_once", 0, 64'(big_if.done), 64'd0);
    runCmd(4'd1, 4'd1, 4'd1, 4'd4, 1'b0, 32'h0, lat, bz);
    checkOutput("sub_z", 0, 64'(big_if.z_flag), 64'd1);
    peekReg(4'd4, 32'd0, "sub_r4");
    runCmd(4'd5, 4'd2, 4'd0, 4'd5, 1'b1, 32'd4, lat, bz);
    peekReg(4'd5, 32'h70, "shl_r5");
    hostWrite(4'd6, 32'd1);
    runCmd(4'd6, 4'd6, 4'd0, 4'd7, 1'b1, 32'd1, lat, bz);
    peekReg(4'd7, 32'h8000_0000, "ror_r7");

    $display("[TB] MUL / DIV");
    hostWrite(4'd1, 32'hFFFF_FFFE);
    hostWrite(4'd2, 32'd3);
    runCmd(4'd10, 4'd1, 4'd2, 4'd8, 1'b0, 32'h0, lat, bz);
    checkOutput("mul_latency", 0, 64'(lat), 64'd4);
    checkOutput("mul_lo", 0, 64'(big_if.lo_out), 64'hFFFF_FFFA);
    checkOutput("mul_hi", 0, 64'(big_if.hi_out), 64'hFFFF_FFFF);
    peekReg(4'd8, 32'd0, "mul_rd_untouched");
    hostWrite(4'd1, 32'hFFFF_FFF9);
    runCmd(4'd11, 4'd1, 4'd0, 4'd0, 1'b1, 32'd2, lat, bz);
    checkOutput("div_lo", 0, 64'(big_if.lo_out), 64'hFFFF_FFFD);
    checkOutput("div_hi", 0, 64'(big_if.hi_out), 64'hFFFF_FFFF);
    hostWrite(4'd9, 32'd9);
    runCmd(4'd11, 4'd9, 4'd0, 4'd0, 1'b1, 32'd0, lat, bz);
    checkOutput("div0_lo", 0, 64'(big_if.lo_out), 64'hFFFF_FFFF);
    checkOutput("div0_hi", 0, 64'(big_if.hi_out), 64'd9);

    $display("[TB] host write corner cases");
    applyStimulus(1'b1, 4'd0, 4'd2, 4'd2, 4'd0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0, 1'b1, 4'd10, 32'hDEAD);
    waitDone(lat, bz);
    peekReg(4'd10, 32'd0, "busy_write_dropped");
    applyStimulus(1'b1, 4'd0, 4'd11, 4'd0, 4'd12, 1'b1, 32'd1, 1'b1, 4'd11, 32'd100);
    waitDone(lat, bz);
    peekReg(4'd12, 32'd101, "same_edge_write");

    $display("[TB] back-to-back commands");
    runCmd(4'd0, 4'd2, 4'd2, 4'd15, 1'b0, 32'h0, lat, bz);
    checkOutput("b2b_ready_in_done", 0, 64'(big_if.cmd_ready), 64'd1);
    runCmd(4'd1, 4'd15, 4'd0, 4'd15, 1'b1, 32'd1, lat, bz);
    checkOutput("b2b_second_latency", 0, 64'(lat), 64'd3);
    peekReg(4'd15, 32'd5, "b2b_r15");

    $display("[TB] reset during a command");
    hostWrite(4'd13, 32'd3);
    applyStimulus(1'b1, 4'd0, 4'd13, 4'd13, 4'd14, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready", 0, 64'(big_if.cmd_ready), 64'd1);
    checkOutput("midrst_done", 0, 64'(big_if.done), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_held", 0, 64'(big_if.cmd_ready), 64'd1);
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midrst_no_done", 0, 64'(big_if.done), 64'd0);
    end
    peekReg(4'd14, 32'd0, "midrst_r14");
    peekReg(4'd13, 32'd0, "midrst_r13");
    checkOutput("midrst_lo", 0, 64'(big_if.lo_out), 64'd0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      clr        = ($urandom_range(0, 199) != 0);
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_op     = 4'($urandom_range(0, 15));
      cmd_ra     = 4'($urandom_range(0, 15));
      cmd_rb     = 4'($urandom_range(0, 15));
      cmd_rd     = 4'($urandom_range(0, 15));
      cmd_imm_en = 1'($urandom_range(0, 1));
      cmd_imm    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      if (cmd_op == 4'd11) begin
        cmd_imm_en = 1'b1;
        cmd_imm    = ($urandom_range(0, 1) == 1) ? (32'd0 - 32'($urandom_range(2, 15)))
                                                 : 32'($urandom_range(0, 15));
      end
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_sel  = 4'($urandom_range(0, 15));
      wr_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom);
      rd_sel  = 4'($urandom_range(0, 15));
    end
    @(posedge clk);
    #1;
    clr       = 1'b1;
    cmd_valid = 1'b0;
    wr_en     = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
